// File: rtl/sw_out_alloc_if.sv
//------------------------------------------------------------------------------
// sw_out_alloc_if : request/grant bundle between router inputs and one output
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sw_out_alloc_if;
    logic [4:0] req;
    logic [4:0] tail;
    logic       out_ready;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       valid_out;
    logic       locked;

    modport master (
        output req, tail, out_ready,
        input  grant, sel, valid_out, locked
    );

    modport slave (
        input  req, tail, out_ready,
        output grant, sel, valid_out, locked
    );
endinterface

`default_nettype wire

// File: rtl/sw_out_alloc.sv
//------------------------------------------------------------------------------
// sw_out_alloc : round-robin allocator for one router output, packet-locking
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sw_out_alloc #(
    parameter int PTR_RST = 0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    sw_out_alloc_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_owner;
    logic [4:0] r_grant;
    logic [2:0] r_sel;
    logic       r_valid;

    logic       w_found;
    logic [2:0] w_win;
    logic [3:0] w_sum;
    logic [2:0] w_idx;

    function automatic logic [2:0] f_next(input logic [2:0] i);
        return (i >= 3'd4) ? 3'd0 : i + 3'd1;
    endfunction

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_sum   = 4'd0;
        w_idx   = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
            if (bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'(PTR_RST);
            r_owner <= 3'd0;
            r_grant <= 5'd0;
            r_sel   <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_grant <= 5'd0;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.out_ready && w_found) begin
                        r_grant <= 5'd1 << w_win;
                        r_sel   <= w_win;
                        r_valid <= 1'b1;
                        if (bus.tail[w_win]) begin
                            r_ptr <= f_next(w_win);
                        end else begin
                            r_state <= S_LOCK;
                            r_owner <= w_win;
                        end
                    end
                end
                S_LOCK: begin
                    // Only the owner may advance; everyone else waits for the tail.
                    if (bus.out_ready && bus.req[r_owner]) begin
                        r_grant <= 5'd1 << r_owner;
                        r_sel   <= r_owner;
                        r_valid <= 1'b1;
                        if (bus.tail[r_owner]) begin
                            r_state <= S_IDLE;
                            r_ptr   <= f_next(r_owner);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.valid_out = r_valid;
    assign bus.locked    = (r_state == S_LOCK);

endmodule

`default_nettype wire

// File: tb/tb_sw_out_alloc.sv
//------------------------------------------------------------------------------
// tb_sw_out_alloc : directed + random checks of sw_out_alloc against a model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sw_out_alloc;

    localparam int TB_PTR_RST = 0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sw_out_alloc_if bus ();

    sw_out_alloc #(.PTR_RST(TB_PTR_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit       m_lock;
    int       m_ptr;
    int       m_owner;
    bit [4:0] e_grant;
    bit [2:0] e_sel;
    bit       e_valid;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant"},  8'(bus.grant),     8'(e_grant));
        check({tag, ".sel"},    8'(bus.sel),       8'(e_sel));
        check({tag, ".valid"},  8'(bus.valid_out), 8'(e_valid));
        check({tag, ".locked"}, 8'(bus.locked),    8'(m_lock));
    endtask

    task automatic model_reset();
        m_lock  = 1'b0;
        m_ptr   = TB_PTR_RST;
        m_owner = 0;
        e_grant = '0;
        e_sel   = '0;
        e_valid = 1'b0;
    endtask

    task automatic model_edge(input bit [4:0] rq, input bit [4:0] tl, input bit rdy);
        int w;
        e_grant = '0;
        e_valid = 1'b0;
        if (!m_lock) begin
            w = -1;
            for (int i = 0; i < 5; i++)
                if (w < 0 && rq[(m_ptr + i) % 5]) w = (m_ptr + i) % 5;
            if (rdy && w >= 0) begin
                e_grant[w] = 1'b1;
                e_sel      = 3'(w);
                e_valid    = 1'b1;
                if (tl[w]) m_ptr = (w + 1) % 5;
                else begin
                    m_lock  = 1'b1;
                    m_owner = w;
                end
            end
        end else if (rdy && rq[m_owner]) begin
            e_grant[m_owner] = 1'b1;
            e_sel            = 3'(m_owner);
            e_valid          = 1'b1;
            if (tl[m_owner]) begin
                m_lock = 1'b0;
                m_ptr  = (m_owner + 1) % 5;
            end
        end
    endtask

    // One clock: drive, advance model at the edge, check 1ns later.
    task automatic step(input string tag, input bit [4:0] rq, input bit [4:0] tl, input bit rdy);
        bus.req       = rq;
        bus.tail      = tl;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(rq, tl, rdy);
        #1;
        check_all(tag);
    endtask

    // Reset pulse in the middle of a cycle; outputs must clear immediately.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.req       = 5'b11111;
        bus.tail      = 5'b11111;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        check_all("reset_init");
        @(negedge clk);
        reset = 1'b0;

        step("first_grant", 5'b11111, 5'b11111, 1'b1);
        step("rr_pre", 5'b11111, 5'b11111, 1'b1);
        mid_reset("reset_mid");

        for (int i = 0; i < 6; i++)
            step("round_robin", 5'b11111, 5'b11111, 1'b1);
        step("rr_to2", 5'b11111, 5'b11111, 1'b1);

        step("pkt_head", 5'b11111, 5'b11011, 1'b1);
        step("pkt_body", 5'b11111, 5'b11011, 1'b1);
        step("pkt_tail", 5'b11111, 5'b11111, 1'b1);
        step("pkt_next", 5'b11111, 5'b11111, 1'b1);

        step("bp_head",   5'b00010, 5'b00000, 1'b1);
        step("bp_stall1", 5'b11111, 5'b11111, 1'b0);
        step("bp_stall2", 5'b11111, 5'b11111, 1'b0);
        step("bp_bubble", 5'b11101, 5'b11111, 1'b1);
        step("bp_body",   5'b11111, 5'b11101, 1'b1);
        step("bp_tail",   5'b11111, 5'b11111, 1'b1);

        step("wrap_set", 5'b01000, 5'b11111, 1'b1);
        step("wrap_w0",  5'b00011, 5'b11111, 1'b1);
        step("wrap_w1",  5'b00011, 5'b11111, 1'b1);

        step("rst_lock3", 5'b01000, 5'b00000, 1'b1);
        step("rst_hold3", 5'b01000, 5'b00000, 1'b1);
        mid_reset("rst_pkt");
        step("rst_fresh", 5'b11111, 5'b11111, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) mid_reset("rand_reset");
            step("random", 5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
